// File: rtl/key_event_source.sv
// rtl/key_event_source.sv - PS/2 scan codes to queued, interrupt-driven key codes for the processor
module key_event_source #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               scan_code,
  input  logic                     scan_done_tick,
  input  logic                     interrupt_ack,
  input  logic                     read_strobe,
  output logic [7:0]               in_port_data,
  output logic                     interrupt,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RD, GAP} state_t;

  state_t        state;
  state_t        next_state;

  logic          break_flag;
  logic          ext_flag;
  logic          map_hit;
  logic [7:0]    map_code;
  logic          evt_valid;
  logic [7:0]    evt_code;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [7:0]    head;
  logic          fifo_full;
  logic          pop;
  logic          push_ok;

  logic          next_interrupt;
  logic [7:0]    next_data;

  // Make-code to firmware key-code lookup
  always_comb begin
    map_hit  = 1'b1;
    map_code = 8'h00;
    case (scan_code)
      8'h1D:   map_code = 8'h57;
      8'h1B:   map_code = 8'h53;
      8'h1C:   map_code = 8'h41;
      8'h23:   map_code = 8'h44;
      8'h43:   map_code = 8'h49;
      8'h4D:   map_code = 8'h50;
      8'h2D:   map_code = 8'h08;
      default: map_hit  = 1'b0;
    endcase
  end

  // Prefix tracking and event generation; a byte following F0/E0 is swallowed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      break_flag <= 1'b0;
      ext_flag   <= 1'b0;
      evt_valid  <= 1'b0;
      evt_code   <= 8'h00;
    end else begin
      evt_valid <= 1'b0;
      if (scan_done_tick) begin
        if (scan_code == 8'hF0) begin
          break_flag <= 1'b1;
        end else if (scan_code == 8'hE0) begin
          ext_flag <= 1'b1;
        end else begin
          break_flag <= 1'b0;
          ext_flag   <= 1'b0;
          evt_valid  <= map_hit && !break_flag && !ext_flag;
          evt_code   <= map_code;
        end
      end
    end
  end

  assign head      = mem[rd_ptr];
  assign fifo_full = (fifo_count == FULL_COUNT);
  assign pop       = (state == WAIT_RD) && read_strobe;
  // When full, a simultaneous pop frees the head slot, which wr_ptr then reuses
  assign push_ok   = evt_valid && (!fifo_full || pop);

  // Event storage; contents are meaningless once the pointers are reset
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= evt_code;
    end
  end

  // FIFO pointers, occupancy and sticky drop flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push_ok) fifo_count <= fifo_count - 1'b1;
      if (evt_valid && !push_ok) overflow <= 1'b1;
    end
  end

  // Presentation state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Presentation next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (fifo_count != '0) next_state = REQ;
      REQ:     if (interrupt_ack)    next_state = WAIT_RD;
      WAIT_RD: if (read_strobe)      next_state = GAP;
      default: next_state = IDLE;
    endcase
  end

  // Output values for the upcoming state; data is zero outside REQ/WAIT_RD
  always_comb begin
    next_interrupt = (next_state == REQ);
    next_data      = 8'h00;
    if (next_state == REQ || next_state == WAIT_RD) next_data = head;
  end

  // Registered outputs so the processor sees glitch-free pins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      interrupt    <= 1'b0;
      in_port_data <= 8'h00;
    end else begin
      interrupt    <= next_interrupt;
      in_port_data <= next_data;
    end
  end

endmodule

// File: tb/tb_key_event_source.sv
// tb/tb_key_event_source.sv - scoreboard bench for key_event_source
module tb_key_event_source;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] scan_code;
  logic       scan_done_tick;
  logic       interrupt_ack;
  logic       read_strobe;
  logic [7:0] in_port_data;
  logic       interrupt;
  logic [2:0] fifo_count;
  logic       overflow;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  logic prev_int = 1'b0;
  logic had_event = 1'b0;
  int   low_cycles = 0;

  key_event_source #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .scan_code(scan_code),
    .scan_done_tick(scan_done_tick),
    .interrupt_ack(interrupt_ack),
    .read_strobe(read_strobe),
    .in_port_data(in_port_data),
    .interrupt(interrupt),
    .fifo_count(fifo_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every new interrupt must present the next expected code
  always @(negedge clk) begin
    if (reset === 1'b1 && interrupt === 1'b1 && prev_int !== 1'b1) begin
      if (had_event) check("irq_low_gap", (low_cycles >= 2), 1);
      if (exp_q.size() == 0) begin
        check("unexpected_irq", in_port_data, 32'hFFFF);
      end else begin
        check("presented_code", in_port_data, exp_q.pop_front());
      end
      had_event  = 1'b1;
      low_cycles = 0;
    end
    if (interrupt !== 1'b1) low_cycles++;
    prev_int = interrupt;
  end

  // Called at a negedge; returns at the next negedge
  task automatic tick(input logic [7:0] c);
    scan_code      = c;
    scan_done_tick = 1'b1;
    @(negedge clk);
    scan_done_tick = 1'b0;
  endtask

  task automatic wait_int();
    for (int i = 0; i < 50 && interrupt !== 1'b1; i++) @(negedge clk);
    if (interrupt !== 1'b1) check("wait_irq_timeout", interrupt, 1);
  endtask

  task automatic service(input logic [7:0] code);
    wait_int();
    check("req_data", in_port_data, code);
    interrupt_ack = 1'b1;
    @(negedge clk);
    interrupt_ack = 1'b0;
    check("ack_drops_irq", interrupt, 0);
    check("ack_holds_data", in_port_data, code);
    read_strobe = 1'b1;
    @(negedge clk);
    read_strobe = 1'b0;
    check("gap_data_zero", in_port_data, 0);
  endtask

  initial begin
    int bad;
    reset = 1'b0;
    scan_code = 8'h00;
    scan_done_tick = 1'b0;
    interrupt_ack = 1'b0;
    read_strobe = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_irq", interrupt, 0);
    check("rst_data", in_port_data, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ovf", overflow, 0);
    reset = 1'b1;
    @(negedge clk);

    // Single key with break sequence; interrupt arrives in cycle 3
    exp_q.push_back(8'h57);
    tick(8'h1D);
    tick(8'hF0);
    check("lat_no_irq_c2", interrupt, 0);
    tick(8'h1D);
    check("lat_irq_c3", interrupt, 1);
    check("lat_data_c3", in_port_data, 8'h57);
    check("single_count", fifo_count, 1);
    service(8'h57);
    check("single_count_after", fifo_count, 0);
    repeat (3) @(negedge clk);

    // Filtering of extended, unmapped and break codes
    tick(8'hE0); tick(8'h1C); tick(8'h7E); tick(8'hF0); tick(8'h1B);
    repeat (4) @(negedge clk);
    check("filter_count", fifo_count, 0);
    check("filter_irq", interrupt, 0);
    exp_q.push_back(8'h44);
    tick(8'h23);
    service(8'h44);
    repeat (3) @(negedge clk);

    // Queue ordering
    exp_q.push_back(8'h41); exp_q.push_back(8'h44);
    exp_q.push_back(8'h49); exp_q.push_back(8'h50);
    tick(8'h1C); tick(8'h23); tick(8'h43); tick(8'h4D);
    repeat (3) @(negedge clk);
    check("order_count", fifo_count, 4);
    check("order_irq", interrupt, 1);
    check("order_head", in_port_data, 8'h41);
    service(8'h41); service(8'h44); service(8'h49); service(8'h50);
    @(negedge clk);
    check("order_drained", fifo_count, 0);
    repeat (3) @(negedge clk);

    // Overflow, then push and pop together while full
    exp_q.push_back(8'h57); exp_q.push_back(8'h53);
    exp_q.push_back(8'h41); exp_q.push_back(8'h44);
    tick(8'h1D); tick(8'h1B); tick(8'h1C); tick(8'h23); tick(8'h43);
    repeat (2) @(negedge clk);
    check("ovf_flag", overflow, 1);
    check("ovf_count", fifo_count, 4);
    check("ovf_head", in_port_data, 8'h57);
    interrupt_ack = 1'b1;
    @(negedge clk);
    interrupt_ack = 1'b0;
    scan_code = 8'h2D;
    scan_done_tick = 1'b1;
    @(negedge clk);
    scan_done_tick = 1'b0;
    read_strobe = 1'b1;
    exp_q.push_back(8'h08);
    @(negedge clk);
    read_strobe = 1'b0;
    check("full_pushpop_count", fifo_count, 4);
    check("full_pushpop_ovf", overflow, 1);
    service(8'h53); service(8'h41); service(8'h44); service(8'h08);
    @(negedge clk);
    check("ovf_drained", fifo_count, 0);
    repeat (3) @(negedge clk);

    // Handshake misuse and long hold
    exp_q.push_back(8'h50);
    tick(8'h4D);
    wait_int();
    read_strobe = 1'b1;
    @(negedge clk);
    read_strobe = 1'b0;
    check("rd_in_req_irq", interrupt, 1);
    check("rd_in_req_count", fifo_count, 1);
    interrupt_ack = 1'b1;
    @(negedge clk);
    interrupt_ack = 1'b0;
    check("misuse_ack_irq", interrupt, 0);
    interrupt_ack = 1'b1;
    @(negedge clk);
    interrupt_ack = 1'b0;
    check("ack_in_wait_irq", interrupt, 0);
    check("ack_in_wait_data", in_port_data, 8'h50);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_port_data !== 8'h50 || interrupt !== 1'b0) bad++;
    end
    check("hold_100_bad_cycles", bad, 0);
    read_strobe = 1'b1;
    @(negedge clk);
    read_strobe = 1'b0;
    check("late_read_data", in_port_data, 0);
    check("late_read_count", fifo_count, 0);
    repeat (3) @(negedge clk);

    // Asynchronous reset while waiting for the read with 3 queued
    exp_q.push_back(8'h41); exp_q.push_back(8'h44); exp_q.push_back(8'h49);
    tick(8'h1C); tick(8'h23); tick(8'h43);
    wait_int();
    interrupt_ack = 1'b1;
    @(negedge clk);
    interrupt_ack = 1'b0;
    check("pre_rst_count", fifo_count, 3);
    #2 reset = 1'b0;
    #1;
    exp_q.delete();
    check("arst_irq", interrupt, 0);
    check("arst_data", in_port_data, 0);
    check("arst_count", fifo_count, 0);
    check("arst_ovf", overflow, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_q.push_back(8'h08);
    tick(8'h2D);
    service(8'h08);
    @(negedge clk);
    check("final_count", fifo_count, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/key_event_source.md
# key_event_source

Producer side of the processor's keyboard input channel: turns raw PS/2 set-2 scan codes into the ASCII-style key codes the processor firmware decodes (W, S, A, D, I, P, r), queues them, and presents them one at a time on the processor's input port. Each key is signalled with an interrupt and held until the firmware has both acknowledged the interrupt and read the port. It sits between the PS/2 receiver (scan_code / scan_done_tick) and the processor's in_port / interrupt / interrupt_ack / read_strobe pins.

## Interface
- DEPTH, 4, event FIFO depth in entries; power of two, ≥2
- clk  in  1  system clock, all logic rising-edge
- reset  in  1  asynchronous, active-low; reset==0 clears all state
- scan_code  in  8  byte from PS/2 receiver, valid only when scan_done_tick=1
- scan_done_tick  in  1  one-cycle strobe, new scan byte
- interrupt_ack  in  1  processor interrupt acknowledge, one-cycle pulse
- read_strobe  in  1  processor INPUT strobe, one-cycle pulse
- in_port_data  out  8  key code to processor in_port; 0x00 when nothing presented
- interrupt  out  1  processor interrupt request
- fifo_count  out  $clog2(DEPTH)+1  entries queued, including the one presented
- overflow  out  1  sticky, a decoded key was dropped because the FIFO was full

## Operation
- Scan decoder, registered, updated only on scan_done_tick:
  - 0xF0 sets break flag; 0xE0 sets ext flag; neither produces an event.
  - Any other byte clears both flags. It produces an event only if both flags were clear and it maps:
    - 0x1D→0x57, 0x1B→0x53, 0x1C→0x41, 0x23→0x44
    - 0x43→0x49, 0x4D→0x50, 0x2D→0x08
  - Unmapped bytes, break codes and extended codes are discarded.
  - Typematic repeats (repeated make codes) each produce an event.
- Event FIFO:
  - Push on a decoded event; pop on completion of a presentation.
  - Push and pop in the same cycle are both honoured, including when full.
  - Push when full with no pop: the event is dropped and overflow is set. overflow clears only on reset.
- Presentation FSM (registered outputs):
  - IDLE: interrupt=0, in_port_data=0x00. Go to REQ when the FIFO is non-empty.
  - REQ: interrupt=1, in_port_data=FIFO head. Go to WAIT_RD on interrupt_ack.
  - WAIT_RD: interrupt=0, in_port_data=head (held). On read_strobe, pop and go to GAP.
  - GAP: interrupt=0, in_port_data=0x00 for exactly one cycle, then IDLE.
- read_strobe outside WAIT_RD is ignored. interrupt_ack outside REQ is ignored.
- in_port_data is never non-zero outside REQ/WAIT_RD. Firmware treats 0x50 as level-sensitive, so no stale code may linger.

## Timing
- Reset values: interrupt=0, in_port_data=0x00, fifo_count=0, overflow=0, break/ext flags=0, FSM=IDLE.
- Decode latency:
  - scan_done_tick high in cycle 0 → decoded event registered by cycle 1 → FIFO count increments in cycle 2.
  - With the FIFO empty and FSM in IDLE, interrupt=1 and in_port_data valid in cycle 3.
- Ack in cycle k (state REQ) → interrupt=0 in cycle k+1. Data stays unchanged.
- read_strobe in cycle m (state WAIT_RD) → fifo_count decrements and in_port_data=0x00 in cycle m+1 (GAP).
  - Next queued event: interrupt=1 in cycle m+3 at the earliest.
- Minimum interrupt-low time between consecutive events: 2 cycles (GAP + IDLE).
- Asynchronous reset mid-presentation drops all queued events and deasserts interrupt immediately. No partial state survives.
- fifo_count is never greater than DEPTH.

## Test plan
- Single key: 0x1D tick, then 0xF0 tick, then 0x1D tick → exactly one interrupt in cycle 3 with in_port_data=0x57. After ack and read_strobe, data returns to 0x00 and fifo_count=0.
- Filtering: 0xE0,0x1C; 0x7E; 0xF0,0x1B → no interrupt, fifo_count stays 0, flags clear afterward. A following 0x23 presents 0x44.
- Queue order: ticks for 0x1C,0x23,0x43,0x4D back-to-back with no ack → fifo_count=4 and interrupt held with 0x41. Serviced in order 0x41,0x44,0x49,0x50, each separated by ≥2 interrupt-low cycles.
- Overflow: DEPTH=4, five mapped make codes with no service → overflow=1, fifo_count=4, fifth event lost. Simultaneous push+pop while full → count stays 4, overflow unchanged.
- Handshake misuse: read_strobe during REQ → ignored, interrupt stays 1. Ack during WAIT_RD → ignored. Ack then read 100 cycles later → data held at head value throughout.
- Reset mid-operation: reset=0 while in WAIT_RD with 3 queued → interrupt=0, in_port_data=0x00, fifo_count=0, overflow=0 asynchronously. After release, a fresh 0x2D tick presents 0x08.
